// File: rtl/mmio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : mmio_pkg                                                    |
// | Purpose    : Shared types and constants for the MMIO I/O unit: UART      |
// |              serializer state encoding, default register addresses and   |
// |              the STATUS register bit layout.                             |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package mmio_pkg;

   // Serializer state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Default register map
   localparam logic [31:0] DEF_UART_ADDR   = 32'hF6FF_F070;
   localparam logic [31:0] DEF_STATUS_ADDR = 32'hF6FF_F074;
   localparam logic [31:0] DEF_HC_ADDR     = 32'hFFFF_FF00;

   // STATUS register layout
   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_EMPTY_BIT = 2;
   localparam int STAT_CNT_LSB   = 8;
   localparam int STAT_CNT_W     = 8;

   // Assemble a STATUS word; every bit not named above reads as 0.
   function automatic logic [31:0] status_word(input logic busy, input logic full,
                                               input logic empty,
                                               input logic [STAT_CNT_W-1:0] count);
      logic [31:0] w;
      w = '0;
      w[STAT_BUSY_BIT]                     = busy;
      w[STAT_FULL_BIT]                     = full;
      w[STAT_EMPTY_BIT]                    = empty;
      w[STAT_CNT_LSB +: STAT_CNT_W]        = count;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mmio_tx_fifo                                                |
// | Purpose    : Byte-wide transmit FIFO feeding the UART serializer.        |
// | Ports      : clk   in   system clock                                     |
// |              rst   in   synchronous active-low reset                     |
// |              push  in   write din (ignored while full)                   |
// |              pop   in   advance the read pointer (ignored while empty)   |
// |              din   in   [7:0] write data                                 |
// |              dout  out  [7:0] head entry (valid while not empty)         |
// |              count out  occupancy, 0..DEPTH                              |
// |              full  out  count == DEPTH                                   |
// |              empty out  count == 0                                       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module mmio_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
   // the natural overflow the modulo-DEPTH wrap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mmio_io_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mmio_io_unit                                                |
// | Purpose    : Memory-mapped I/O block: UART transmitter (8N1, FIFO fed),  |
// |              STATUS register and a clearable free-running cycle counter. |
// | Ports      : clk      in   system clock                                  |
// |              rst      in   synchronous active-low reset                  |
// |              addr     in   [31:0] access address                         |
// |              w_data   in   [31:0] store data                             |
// |              is_store in   store strobe                                  |
// |              is_load  in   load strobe                                   |
// |              r_data   out  [31:0] load data (combinational)              |
// |              hit      out  addr matches a register of this block         |
// |              stall    out  CPU hold: UART store while the FIFO is full   |
// |              uart_tx  out  serial line, idles high                       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module mmio_io_unit
   import mmio_pkg::*;
#(
   parameter int          BAUD_DIV    = 868,
   parameter int          FIFO_DEPTH  = 16,
   parameter int          CNT_WIDTH   = 32,
   parameter logic [31:0] UART_ADDR   = DEF_UART_ADDR,
   parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter logic [31:0] HC_ADDR     = DEF_HC_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   input  logic        is_store,
   input  logic        is_load,
   output logic [31:0] r_data,
   output logic        hit,
   output logic        stall,
   output logic        uart_tx
);

   localparam int            BW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam int            FCW       = $clog2(FIFO_DEPTH) + 1;

   tx_state_e      state_q, state_d;
   logic [BW-1:0]  baud_q,  baud_d;
   logic [2:0]     bit_q,   bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q,    tx_d;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic           w_uart_store;
   logic           w_push;
   logic           w_pop;
   logic [7:0]     w_dout;
   logic [FCW-1:0] w_count;
   logic           w_full;
   logic           w_empty;
   logic           w_busy;
   logic           w_baud_end;
   logic [31:0]    w_cnt_lo;
   logic           w_unused_wdata;

   // Only the low byte of store data ever reaches the UART.
   assign w_unused_wdata = ^w_data[31:8];

   assign hit          = (addr == UART_ADDR) || (addr == STATUS_ADDR) || (addr == HC_ADDR);
   assign w_uart_store = is_store && (addr == UART_ADDR);
   // Stall looks only at the registered full flag: a pop on this edge does not
   // release the CPU until the next cycle. Held low while in reset.
   assign stall        = rst && w_uart_store && w_full;
   assign w_push       = rst && w_uart_store && !w_full;

   mmio_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_data[7:0]),
      .dout  (w_dout),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   // ---------------------------------------------------------------- serializer
   assign w_baud_end = (baud_q == BAUD_LAST);

   // tx_d is the line level for the state being entered, so the output flop
   // changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      w_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!w_empty) begin
               w_pop   = 1'b1;
               shift_d = w_dout;
               baud_d  = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (w_baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_DATA: begin
            if (w_baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         ST_STOP: begin
            if (w_baud_end) begin
               baud_d = '0;
               // Chain straight into the next frame when data is waiting.
               if (!w_empty) begin
                  w_pop   = 1'b1;
                  shift_d = w_dout;
                  state_d = ST_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign uart_tx = tx_q;

   // ------------------------------------------------------------- cycle counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (is_store && (addr == HC_ADDR)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   generate
      if (CNT_WIDTH >= 32) begin : g_cnt_wide
         assign w_cnt_lo = cnt_q[31:0];
      end else begin : g_cnt_narrow
         assign w_cnt_lo = 32'(cnt_q);
      end
   endgenerate

   // ---------------------------------------------------------------- read mux
   assign w_busy = (state_q != ST_IDLE) || !w_empty;

   always_comb begin
      r_data = 32'd0;
      if (is_load) begin
         if (addr == HC_ADDR) begin
            r_data = w_cnt_lo;
         end else if (addr == STATUS_ADDR) begin
            r_data = status_word(w_busy, w_full, w_empty, STAT_CNT_W'(w_count));
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_mmio_io_unit                                             |
// | Purpose    : Scoreboard bench for mmio_io_unit. A transaction-level      |
// |              model predicts load/stall/hit responses and the sequence    |
// |              and start time of every UART frame; monitors compare.       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_mmio_io_unit;

   localparam int          B      = 4;
   localparam int          D      = 4;
   localparam int          CW     = 8;
   localparam logic [31:0] A_UART = 32'hF6FF_F070;
   localparam logic [31:0] A_STAT = 32'hF6FF_F074;
   localparam logic [31:0] A_HC   = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] w_data = 32'd0;
   logic        is_store = 1'b0;
   logic        is_load = 1'b0;
   logic [31:0] r_data;
   logic        hit;
   logic        stall;
   logic        uart_tx;

   mmio_io_unit #(
      .BAUD_DIV    (B),
      .FIFO_DEPTH  (D),
      .CNT_WIDTH   (CW),
      .UART_ADDR   (A_UART),
      .STATUS_ADDR (A_STAT),
      .HC_ADDR     (A_HC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .w_data   (w_data),
      .is_store (is_store),
      .is_load  (is_load),
      .r_data   (r_data),
      .hit      (hit),
      .stall    (stall),
      .uart_tx  (uart_tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ------------------------------------------------------------ reference model
   // FIFO = bytes accepted but not yet started; a frame occupies 10*B edges
   // after the edge that starts it.
   typedef struct { logic [7:0] b; int c; } frame_t;
   typedef struct { logic [31:0] rd; logic st; logic ht; } resp_t;

   logic [7:0] m_fifo[$];
   bit         m_active = 1'b0;
   int         m_fe = 0;
   logic [7:0] m_cnt = 8'd0;
   frame_t     exp_frames[$];
   resp_t      exp_resp[$];

   function automatic logic [31:0] m_rdata(input logic ld, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = m_fifo.size();
      if (ld && a == A_HC) begin
         v = {24'd0, m_cnt};
      end else if (ld && a == A_STAT) begin
         v[0]    = m_active || (n != 0);
         v[1]    = (n == D);
         v[2]    = (n == 0);
         v[15:8] = 8'(n);
      end
      return v;
   endfunction

   task automatic drive(input bit r, input bit st, input bit ld,
                        input logic [31:0] a, input logic [31:0] wd);
      resp_t e;
      rst = r; is_store = st; is_load = ld; addr = a; w_data = wd;
      if (st || ld) begin
         e.rd = m_rdata(ld, a);
         e.st = r && st && (a == A_UART) && (m_fifo.size() == D);
         e.ht = (a == A_UART) || (a == A_STAT) || (a == A_HC);
         exp_resp.push_back(e);
      end
   endtask

   // Clock edge, then apply the same inputs to the model.
   task automatic advance();
      int     pre;
      bit     can_pop;
      frame_t f;
      @(posedge clk);
      #1;
      if (!rst) begin
         m_fifo.delete();
         exp_frames.delete();
         m_active = 1'b0;
         m_fe     = 0;
         m_cnt    = 8'd0;
      end else begin
         pre     = m_fifo.size();
         can_pop = !m_active;
         if (m_active) begin
            m_fe++;
            if (m_fe == 10 * B) begin
               m_active = 1'b0;
               can_pop  = 1'b1;
            end
         end
         if (can_pop && pre > 0) begin
            f.b = m_fifo.pop_front();
            f.c = cyc;
            exp_frames.push_back(f);
            m_active = 1'b1;
            m_fe     = 0;
         end
         if (is_store && addr == A_UART && pre < D) m_fifo.push_back(w_data[7:0]);
         m_cnt = (is_store && addr == A_HC) ? 8'd0 : m_cnt + 8'd1;
      end
   endtask

   task automatic cycle(input bit r, input bit st, input bit ld,
                        input logic [31:0] a, input logic [31:0] wd);
      drive(r, st, ld, a, wd);
      advance();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic load_expect(input string nm, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 1'b0, 1'b1, a, 32'd0);
      #2;
      check(nm, r_data, exp);
      advance();
   endtask

   // ------------------------------------------------------- response monitor
   always @(negedge clk) begin
      resp_t e;
      if (is_store || is_load) begin
         if (exp_resp.size() == 0) begin
            n_chk++;
            $display("FAIL resp: DUT strobe with no expected response at cycle %0d", cyc);
         end else begin
            e = exp_resp.pop_front();
            check("r_data", r_data, e.rd);
            check("stall", {31'd0, stall}, {31'd0, e.st});
            check("hit", {31'd0, hit}, {31'd0, e.ht});
         end
      end
   end

   // ------------------------------------------------------------ UART monitor
   bit         in_frame = 1'b0;
   int         k = 0;
   int         st_cyc = 0;
   logic       lvl = 1'b1;
   logic [7:0] rx = 8'd0;
   bit         bad = 1'b0;
   int         frames_done = 0;

   always @(negedge clk) begin
      frame_t f;
      if (rst !== 1'b1) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (uart_tx === 1'b0) begin
            in_frame = 1'b1; k = 1; st_cyc = cyc; lvl = 1'b0; bad = 1'b0; rx = 8'd0;
         end
      end else begin
         if (k % B == 0) begin
            lvl = uart_tx;
            if (k / B >= 1 && k / B <= 8) rx[k / B - 1] = uart_tx;
         end else if (uart_tx !== lvl) begin
            bad = 1'b1;
         end
         k++;
         if (k == 10 * B) begin
            in_frame = 1'b0;
            frames_done++;
            if (lvl !== 1'b1) bad = 1'b1;
            if (exp_frames.size() == 0) begin
               n_chk++;
               $display("FAIL frame: unexpected frame byte %h started at cycle %0d", rx, st_cyc);
            end else begin
               f = exp_frames.pop_front();
               check("frame_byte", {24'd0, rx}, {24'd0, f.b});
               check("frame_start_cycle", 32'(st_cyc), 32'(f.c));
               check("frame_bit_timing", {31'd0, bad}, 32'd0);
            end
         end
      end
   end

   task automatic wait_drain(input int max);
      int g;
      g = 0;
      while ((m_fifo.size() != 0 || m_active || exp_frames.size() != 0 || in_frame) && g < max) begin
         idle(1);
         g++;
      end
      check("drain_within_bound", {31'd0, (g < max)}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int guard;
      bit stalled_seen;
      bit was_full;
      int frames_before;
      int op;

      // reset, with a STATUS read while still in reset
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b0, 1'b0, 1'b1, A_STAT, 32'd0);
      #2;
      check("status_in_reset", r_data, 32'h0000_0004);
      advance();
      check("tx_after_reset", {31'd0, uart_tx}, 32'd1);
      check("stall_after_reset", {31'd0, stall}, 32'd0);

      // cycle counter: 300 edges after reset, then clear
      idle(300);
      load_expect("hc_300_cycles", A_HC, 32'd44);
      cycle(1'b1, 1'b1, 1'b0, A_HC, 32'h1234_5678);
      idle(1);
      load_expect("hc_after_clear", A_HC, 32'd1);

      // single frame
      cycle(1'b1, 1'b1, 1'b0, A_UART, 32'hFFFF_FFA5);
      idle(50);
      load_expect("status_idle_after_a5", A_STAT, 32'h0000_0004);

      // burst: five stores fill FIFO, sixth stalls until a pop frees a slot
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, A_UART, 32'($urandom_range(0, 255)));
      guard = 0;
      stalled_seen = 1'b0;
      do begin
         drive(1'b1, 1'b1, 1'b0, A_UART, 32'h0000_005A);
         #2;
         if (stall === 1'b1) stalled_seen = 1'b1;
         was_full = (m_fifo.size() == D);
         advance();
         guard++;
      end while (was_full && guard < 200);
      check("burst_stall_seen", {31'd0, stalled_seen}, 32'd1);
      check("burst_stall_released", {31'd0, (guard < 200)}, 32'd1);
      wait_drain(2000);

      // three queued while the serializer sits in DATA
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, A_UART, 32'(8'h30 + i));
      idle(6);
      load_expect("status_3q_data", A_STAT, 32'h0000_0301);
      wait_drain(2000);

      // reset during data bit 3 with more bytes queued
      cycle(1'b1, 1'b1, 1'b0, A_UART, 32'h0000_003C);
      cycle(1'b1, 1'b1, 1'b0, A_UART, 32'h0000_0011);
      cycle(1'b1, 1'b1, 1'b0, A_UART, 32'h0000_0022);
      idle(16);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("tx_high_at_reset_edge", {31'd0, uart_tx}, 32'd1);
      drive(1'b0, 1'b0, 1'b1, A_STAT, 32'd0);
      #2;
      check("status_after_midframe_reset", r_data, 32'h0000_0004);
      advance();
      frames_before = frames_done;
      idle(100);
      check("no_frame_after_reset", 32'(frames_done), 32'(frames_before));
      check("tx_idle_after_reset", {31'd0, uart_tx}, 32'd1);

      // non-hit load, ignored store to STATUS
      drive(1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'd0);
      #2;
      check("nohit_rdata", r_data, 32'd0);
      check("nohit_hit", {31'd0, hit}, 32'd0);
      advance();
      cycle(1'b1, 1'b1, 1'b0, A_STAT, 32'hFFFF_FFFF);
      load_expect("status_after_status_store", A_STAT, 32'h0000_0004);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         op = int'($urandom_range(0, 11));
         case (op)
            0, 1, 2, 3: cycle(1'b1, 1'b1, 1'b0, A_UART, $urandom);
            4:          cycle(1'b1, 1'b1, 1'b0, A_HC, $urandom);
            5:          cycle(1'b1, 1'b1, 1'b0, A_STAT, $urandom);
            6, 7:       cycle(1'b1, 1'b0, 1'b1, A_STAT, 32'd0);
            8:          cycle(1'b1, 1'b0, 1'b1, A_HC, 32'd0);
            9:          cycle(1'b1, 1'b0, 1'b1, $urandom, 32'd0);
            10:         cycle(1'b1, 1'b0, 1'b1, A_UART, 32'd0);
            default:    idle(int'($urandom_range(1, 30)));
         endcase
      end
      wait_drain(3000);
      check("frames_all_seen", 32'(exp_frames.size()), 32'd0);
      check("responses_all_seen", 32'(exp_resp.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
